// File: rtl/uart_pwm_hub.sv
// UART-driven PWM hub: 8N1 receiver, A5/CH/DUTY parser, shared-counter PWM, link failsafe.
// Define UART_PWM_HUB_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_pwm_hub #(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 115200,
  parameter int N_CH        = 4,
  parameter int PWM_W       = 8,
  parameter int TIMEOUT_CYC = 25000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic [N_CH-1:0] pwm,
  output logic            frame_ok,
  output logic            frame_err,
  output logic            failsafe
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int TW  = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [CW-1:0] HALF  = CW'(DIV / 2);
  localparam logic [CW-1:0] DLAST = CW'(DIV - 1);
  localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    SYNC  = 8'hA5;
  localparam logic [7:0]    NCH8  = 8'(N_CH);

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rstate_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_CH,
    P_DUTY
`ifdef UART_PWM_HUB_CHECKSUM_EN
    , P_CHK
`endif
  } pstate_t;

  logic rx_m, rx_s, rx_d;
  logic fall;

  rstate_t rs, rs_n;
  logic [CW-1:0] rc, rc_n;
  logic [2:0] rb, rb_n;
  logic [7:0] rsh, rsh_n;
  logic rvld, rvld_n;
  logic rerr, rerr_n;

  pstate_t ps, ps_n;
  logic [2:0] ch, ch_n;
  logic fok, fok_n;
  logic ferr, ferr_n;
  logic wr;
  logic [7:0] wbyte;
`ifdef UART_PWM_HUB_CHECKSUM_EN
  logic [7:0] db, db_n;
`endif

  logic [PWM_W-1:0] shadow [N_CH];
  logic [PWM_W-1:0] duty [N_CH];
  logic [PWM_W-1:0] pc;
  logic [N_CH-1:0] pwm_q;
  logic [TW-1:0] tc, tc_inc;
  logic fs;

  // rx_d resets low, so a start edge needs a synchronised high first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rx_m, rx_s, rx_d} <= 3'b000;
    end else begin
      {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};
    end
  end

  assign fall = rx_d & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs   <= R_IDLE;
      rc   <= '0;
      rb   <= '0;
      rsh  <= '0;
      rvld <= 1'b0;
      rerr <= 1'b0;
    end else begin
      rs   <= rs_n;
      rc   <= rc_n;
      rb   <= rb_n;
      rsh  <= rsh_n;
      rvld <= rvld_n;
      rerr <= rerr_n;
    end
  end

  always_comb begin
    rs_n   = rs;
    rc_n   = rc;
    rb_n   = rb;
    rsh_n  = rsh;
    rvld_n = 1'b0;
    rerr_n = 1'b0;
    unique case (rs)
      R_IDLE: begin
        if (fall) begin
          rs_n = R_START;
          rc_n = '0;
        end
      end
      R_START: begin
        if (rc == HALF) begin
          rc_n = '0;
          rb_n = '0;
          rs_n = rx_s ? R_IDLE : R_DATA;
        end else begin
          rc_n = rc + 1'b1;
        end
      end
      R_DATA: begin
        if (rc == DLAST) begin
          rc_n  = '0;
          rsh_n = {rx_s, rsh[7:1]};
          rb_n  = rb + 1'b1;
          if (rb == 3'd7) rs_n = R_STOP;
        end else begin
          rc_n = rc + 1'b1;
        end
      end
      R_STOP: begin
        if (rc == DLAST) begin
          rs_n   = R_IDLE;
          rvld_n = rx_s;
          rerr_n = ~rx_s;
        end else begin
          rc_n = rc + 1'b1;
        end
      end
      default: rs_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps   <= P_IDLE;
      ch   <= '0;
      fok  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ps   <= ps_n;
      ch   <= ch_n;
      fok  <= fok_n;
      ferr <= ferr_n;
    end
  end

`ifdef UART_PWM_HUB_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db <= '0;
    end else begin
      db <= db_n;
    end
  end
`endif

  always_comb begin
    ps_n   = ps;
    ch_n   = ch;
    fok_n  = 1'b0;
    ferr_n = 1'b0;
    wr     = 1'b0;
    wbyte  = rsh;
`ifdef UART_PWM_HUB_CHECKSUM_EN
    db_n   = db;
`endif
    unique case (1'b1)
      rerr: begin
        ferr_n = 1'b1;
        ps_n   = P_IDLE;
      end
      rvld: begin
        unique case (ps)
          P_IDLE: begin
            if (rsh == SYNC) ps_n = P_CH;
          end
          P_CH: begin
            if (rsh >= NCH8) begin
              ferr_n = 1'b1;
              ps_n   = P_IDLE;
            end else begin
              ch_n = rsh[2:0];
              ps_n = P_DUTY;
            end
          end
          P_DUTY: begin
`ifdef UART_PWM_HUB_CHECKSUM_EN
            db_n = rsh;
            ps_n = P_CHK;
`else
            wr    = 1'b1;
            fok_n = 1'b1;
            ps_n  = P_IDLE;
`endif
          end
`ifdef UART_PWM_HUB_CHECKSUM_EN
          P_CHK: begin
            ps_n = P_IDLE;
            if (rsh == (SYNC ^ {5'b0, ch} ^ db)) begin
              wr    = 1'b1;
              wbyte = db;
              fok_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end
`endif
          default: ps_n = P_IDLE;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
    end else if (wr) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch == 3'(i)) shadow[i] <= PWM_W'(wbyte) << (PWM_W - 8);
      end
    end
  end

  // duty is zeroed under failsafe so outputs only resume at a wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      pwm_q <= '0;
      for (int i = 0; i < N_CH; i++) duty[i] <= '0;
    end else begin
      pc <= pc + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        if (fs) duty[i] <= '0;
        else if (&pc) duty[i] <= shadow[i];
        pwm_q[i] <= ~fs & (pc < duty[i]);
      end
    end
  end

  assign tc_inc = tc + 1'b1;

  // keyed on fok_n so failsafe drops in the cycle frame_ok is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc <= '0;
      fs <= 1'b0;
    end else if (fok_n) begin
      tc <= '0;
      fs <= 1'b0;
    end else begin
      if (tc != TLIM) tc <= tc_inc;
      if (tc_inc >= TLIM) fs <= 1'b1;
    end
  end

  assign pwm       = pwm_q;
  assign frame_ok  = fok;
  assign frame_err = ferr;
  assign failsafe  = fs;

endmodule

// File: tb/tb_uart_pwm_hub.sv
// Bench for uart_pwm_hub: vector table, failsafe/reset sequences, random byte streams.
// Honours UART_PWM_HUB_CHECKSUM_EN when compiled with it.
module tb_uart_pwm_hub;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int N_CH   = 4;
  localparam int PWM_W  = 8;
  localparam int TO     = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic [N_CH-1:0] pwm;
  logic frame_ok, frame_err, failsafe;

  uart_pwm_hub #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .N_CH(N_CH),
    .PWM_W(PWM_W),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .pwm(pwm),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .failsafe(failsafe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         ok;
  } sb_t;

  typedef struct {
    logic [7:0] lead;
    logic [7:0] ch;
    logic [7:0] duty;
    int         stop_bad;
    int         exp_ok;
    int         exp_err;
  } vec_t;

  sb_t  q[$];
  vec_t tbl[10];
  int   mduty[N_CH];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, ok_cyc = 0, fs_cyc = 0;
  int n_ok = 0, n_err = 0;
  logic fs_at_ok = 1'b0;
  logic fs_d = 1'b0;
  int b_ok, b_err, eo, ee, t, quiet;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (frame_ok) begin
      n_ok     <= n_ok + 1;
      ok_cyc   <= cyc;
      fs_at_ok <= failsafe;
    end
    if (frame_err) n_err <= n_err + 1;
    if (failsafe && !fs_d) fs_cyc <= cyc;
    fs_d <= failsafe;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_ok;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_q();
    foreach (q[i]) send_byte(q[i].b, q[i].ok);
  endtask

  task automatic push_frame(input logic [7:0] lead, input logic [7:0] ch,
                            input logic [7:0] duty, input bit badchk,
                            input int stop_bad);
`ifdef UART_PWM_HUB_CHECKSUM_EN
    logic [7:0] c;
    c = 8'hA5 ^ ch ^ duty;
    if (badchk) c = ~c;
`endif
    q.push_back('{lead, stop_bad != 0});
    q.push_back('{ch, stop_bad != 1});
    q.push_back('{duty, stop_bad != 2});
`ifdef UART_PWM_HUB_CHECKSUM_EN
    q.push_back('{c, stop_bad != 3});
`endif
  endtask

  // Frame rules applied byte by byte; updates mduty for accepted frames.
  task automatic model(input sb_t s[$], output int xo, output int xe);
    int st;
    logic [7:0] mch, md;
    st = 0;
    mch = 8'h00;
    md = 8'h00;
    xo = 0;
    xe = 0;
    foreach (s[i]) begin
      if (!s[i].ok) begin
        xe++;
        st = 0;
      end else if (st == 0) begin
        if (s[i].b == 8'hA5) st = 1;
      end else if (st == 1) begin
        if (int'(s[i].b) >= N_CH) begin
          xe++;
          st = 0;
        end else begin
          mch = s[i].b;
          st = 2;
        end
      end else if (st == 2) begin
        md = s[i].b;
`ifdef UART_PWM_HUB_CHECKSUM_EN
        st = 3;
`else
        mduty[int'(mch)] = int'(md);
        xo++;
        st = 0;
`endif
      end else begin
        if (s[i].b == (8'hA5 ^ mch ^ md)) begin
          mduty[int'(mch)] = int'(md);
          xo++;
        end else begin
          xe++;
        end
        st = 0;
      end
    end
  endtask

  task automatic measure(input string tag);
    int hi[N_CH];
    for (int c = 0; c < N_CH; c++) hi[c] = 0;
    repeat (260) @(negedge clk);
    repeat (256) begin
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) hi[c] += int'(pwm[c]);
    end
    for (int c = 0; c < N_CH; c++)
      chk($sformatf("%s high ch%0d", tag, c), hi[c], mduty[c]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hA5, 8'h02, 8'h80, -1, 1, 0};
    tbl[1] = '{8'hA5, 8'h07, 8'h40, -1, 0, 1};
    tbl[2] = '{8'hA5, 8'h01, 8'hFF, -1, 1, 0};
    tbl[3] = '{8'hA5, 8'h03, 8'hA5, -1, 1, 0};
    tbl[4] = '{8'h5A, 8'h01, 8'h22, -1, 0, 0};
    tbl[5] = '{8'hA5, 8'h01, 8'h33,  1, 0, 1};
    tbl[6] = '{8'hA5, 8'h00, 8'h10, -1, 1, 0};
    tbl[7] = '{8'hA5, 8'h04, 8'h00, -1, 0, 1};
    tbl[8] = '{8'hA5, 8'h03, 8'h00, -1, 1, 0};
    tbl[9] = '{8'hA5, 8'h00, 8'h55,  2, 0, 1};
    for (int c = 0; c < N_CH; c++) mduty[c] = 0;

    repeat (5) @(negedge clk);
    chk("reset pwm", pwm, 0);
    chk("reset frame_ok", frame_ok, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset failsafe", failsafe, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int r = 0; r < 10; r++) begin
      q.delete();
      push_frame(tbl[r].lead, tbl[r].ch, tbl[r].duty, 1'b0, tbl[r].stop_bad);
      b_ok = n_ok;
      b_err = n_err;
      send_q();
      chk($sformatf("row%0d frame_ok", r), n_ok - b_ok, tbl[r].exp_ok);
      chk($sformatf("row%0d frame_err", r), n_err - b_err, tbl[r].exp_err);
      if (tbl[r].exp_ok != 0) begin
        mduty[int'(tbl[r].ch)] = int'(tbl[r].duty);
        chk($sformatf("row%0d failsafe", r), failsafe, 0);
        measure($sformatf("row%0d", r));
      end
    end

    q.delete();
    push_frame(8'hA5, 8'h02, 8'h80, 1'b0, -1);
    model(q, eo, ee);
    b_ok = n_ok;
    send_q();
    chk("fs frame_ok", n_ok - b_ok, eo);
    t = 0;
    while (!failsafe && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("fs raised", failsafe, 1);
    @(negedge clk);
    chk("fs delay", fs_cyc - ok_cyc, TO - 1);
    chk("fs pwm next", pwm, 0);
    quiet = 0;
    repeat (300) begin
      @(negedge clk);
      if (pwm != '0) quiet++;
    end
    chk("fs pwm held", quiet, 0);
    chk("fs held", failsafe, 1);
    q.delete();
    push_frame(8'hA5, 8'h00, 8'h10, 1'b0, -1);
    model(q, eo, ee);
    b_ok = n_ok;
    send_q();
    chk("fs clear ok", n_ok - b_ok, 1);
    chk("fs low at ok", fs_at_ok, 0);
    chk("fs cleared", failsafe, 0);
    measure("fs resume");

    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    rx = 1'b0;
    repeat (DIV / 2) @(negedge clk);
    b_ok = n_ok;
    b_err = n_err;
    rst = 1'b1;
    #1;
    chk("rst pwm", pwm, 0);
    chk("rst frame_ok", frame_ok, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst failsafe", failsafe, 0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    chk("rst no ok", n_ok - b_ok, 0);
    chk("rst no err", n_err - b_err, 0);
    for (int c = 0; c < N_CH; c++) mduty[c] = 0;
    q.delete();
    push_frame(8'hA5, 8'h03, 8'h77, 1'b0, -1);
    b_ok = n_ok;
    send_q();
    chk("rst next ok", n_ok - b_ok, 1);
    mduty[3] = 8'h77;
    measure("rst next");

`ifdef UART_PWM_HUB_CHECKSUM_EN
    q.delete();
    q.push_back('{8'hA5, 1'b1});
    q.push_back('{8'h01, 1'b1});
    q.push_back('{8'h10, 1'b1});
    q.push_back('{8'hB4, 1'b1});
    b_ok = n_ok;
    b_err = n_err;
    send_q();
    chk("chk good ok", n_ok - b_ok, 1);
    chk("chk good err", n_err - b_err, 0);
    mduty[1] = 8'h10;
    q.delete();
    q.push_back('{8'hA5, 1'b1});
    q.push_back('{8'h01, 1'b1});
    q.push_back('{8'h20, 1'b1});
    q.push_back('{8'h00, 1'b1});
    b_ok = n_ok;
    b_err = n_err;
    send_q();
    chk("chk bad ok", n_ok - b_ok, 0);
    chk("chk bad err", n_err - b_err, 1);
    q.delete();
    push_frame(8'hA5, 8'h00, 8'h44, 1'b0, -1);
    send_q();
    mduty[0] = 8'h44;
    measure("chk");
`endif

    for (int rnd = 0; rnd < 2; rnd++) begin
      q.delete();
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 4))
          0, 1: push_frame(8'hA5, 8'($urandom_range(0, N_CH - 1)),
                           8'($urandom_range(0, 255)),
                           1'($urandom_range(0, 1)), -1);
          2: push_frame(8'hA5, 8'($urandom_range(N_CH, 255)),
                        8'($urandom_range(0, 255)), 1'b0, -1);
          3: q.push_back('{8'($urandom_range(0, 255)), 1'b1});
          default: q.push_back('{8'($urandom_range(0, 255)), 1'b0});
        endcase
      end
      q.push_back('{8'h00, 1'b0});
      push_frame(8'hA5, 8'($urandom_range(0, N_CH - 1)),
                 8'($urandom_range(1, 255)), 1'b0, -1);
      model(q, eo, ee);
      b_ok = n_ok;
      b_err = n_err;
      send_q();
      chk($sformatf("rand%0d ok", rnd), n_ok - b_ok, eo);
      chk($sformatf("rand%0d err", rnd), n_err - b_err, ee);
      chk($sformatf("rand%0d failsafe", rnd), failsafe, 0);
      measure($sformatf("rand%0d", rnd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
